// File: rtl/alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_sched_pkg
// Shared types and constants for the ALU operation scheduler.
//   op_e      : 2-bit opcode, every encoding is a legal operation
//   state_e   : scheduler FSM states
//   DATA_W    : operand width
//   RES_W     : result width
//   MUL_STEPS : shift-add iterations for one multiply
//   STEP_W    : width of the multiply step counter
// -----------------------------------------------------------------------------
package alu_sched_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CMP = 2'd2,
        OP_MUL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DATA_W    = 8;
    localparam int RES_W     = 16;
    localparam int MUL_STEPS = 8;
    localparam int STEP_W    = $clog2(MUL_STEPS);

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search for a winner starts at the pointer; after
// an accepted grant the pointer moves to winner+1 (mod NREQ), so every
// requester that keeps its request up is served within NREQ grants.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   advance    : grant was accepted this cycle, move the pointer
//   grant      : one-hot grant, combinational from req and the pointer
// -----------------------------------------------------------------------------
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    int             j;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Candidate index walks from the pointer and wraps at NREQ.
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j[IDW-1:0]]) begin
                found              = 1'b1;
                grant[j[IDW-1:0]] = 1'b1;
                win                = j[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
// Shares one 8-bit add/sub adder between NREQ requesters. ADD, SUB and CMP
// complete in the accept cycle; MUL runs as 8 shift-add steps over the same
// adder. One operation is in flight at a time; its 16-bit result is returned
// over a valid/ready channel tagged with the requester id.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester request
//   req_ready   : one-hot accept (only in IDLE)
//   req_op      : per-requester 2-bit opcode (ADD, SUB, CMP, MUL)
//   req_a/req_b : per-requester 8-bit unsigned operands
//   rsp_valid   : result available (RESP state)
//   rsp_ready   : consumer accepts result
//   rsp_id      : requester owning the result
//   rsp_result  : 16-bit result
//   op_count    : response handshake counter, wraps (ALU_SCHED_STATS_EN only)
//   busy        : high whenever the FSM is not in IDLE
// Build option: define ALU_SCHED_STATS_EN to add the op_count output.
// -----------------------------------------------------------------------------
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*2-1:0]    req_op,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [RES_W-1:0]     rsp_result,
`ifdef ALU_SCHED_STATS_EN
    output logic [15:0]          op_count,
`endif
    output logic                 busy
);

    state_e              state;
    state_e              state_nxt;
    logic [NREQ-1:0]     grant;
    logic                hs_in;
    logic                last_step;

    logic [IDW-1:0]      sel_idx;
    op_e                 sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [DATA_W-1:0]   acc_hi;
    logic [STEP_W-1:0]   step_cnt;

    logic [DATA_W-1:0]   add_x;
    logic [DATA_W-1:0]   add_y;
    logic                add_sub;
    logic [DATA_W:0]     sum9;

    // Result formatting for the single-cycle ops. For SUB/CMP sum9[8] is the
    // sign of a-b (set exactly when a < b).
    function automatic logic [RES_W-1:0] alu_result(input op_e op, input logic [DATA_W:0] s);
        case (op)
            OP_ADD:  return {7'b0, s};
            OP_SUB:  return {{7{s[DATA_W]}}, s};
            OP_CMP:  return {8'h00, {8{~s[DATA_W]}}};
            default: return '0;
        endcase
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (hs_in),
        .grant   (grant)
    );

    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign hs_in     = |(req_valid & req_ready);
    assign last_step = (step_cnt == STEP_W'(MUL_STEPS - 1));

    // Operand mux from the granted requester.
    always_comb begin
        sel_idx = '0;
        sel_op  = OP_ADD;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_idx = IDW'(i);
                sel_op  = op_e'(req_op[i*2 +: 2]);
                sel_a   = req_a[i*8 +: 8];
                sel_b   = req_b[i*8 +: 8];
            end
        end
    end

    // Shared 9-bit adder: operands from the request in IDLE, from the
    // multiply accumulator during MUL. Subtract is x + ~y + 1 on 9 bits.
    always_comb begin
        add_x   = sel_a;
        add_y   = sel_b;
        add_sub = (sel_op == OP_SUB) || (sel_op == OP_CMP);
        if (state == ST_MUL) begin
            add_x   = acc_hi;
            add_y   = b_r[0] ? a_r : '0;
            add_sub = 1'b0;
        end
        sum9 = {1'b0, add_x} + (add_sub ? ~{1'b0, add_y} : {1'b0, add_y})
             + {{DATA_W{1'b0}}, add_sub};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (hs_in) begin
                    state_nxt = (sel_op == OP_MUL) ? ST_MUL : ST_RESP;
                end
            end
            ST_MUL: begin
                if (last_step) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Response registers and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt   <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else if (hs_in) begin
            step_cnt <= '0;
            rsp_id   <= sel_idx;
            if (sel_op != OP_MUL) begin
                rsp_result <= alu_result(sel_op, sum9);
            end
        end else if (state == ST_MUL) begin
            step_cnt <= step_cnt + 1'b1;
            if (last_step) begin
                rsp_result <= {sum9, b_r[DATA_W-1:1]};
            end
        end
    end

    // Multiply datapath: {acc_hi, b_r} is the product register. Each step
    // adds a into the upper half when the current multiplier bit (b_r[0]) is
    // set, then shifts the 17-bit {carry, sum, b_r} right by one, retiring
    // one multiplier bit and filling in one product bit.
    always_ff @(posedge clk) begin
        if (hs_in) begin
            a_r    <= sel_a;
            b_r    <= sel_b;
            acc_hi <= '0;
        end else if (state == ST_MUL) begin
            acc_hi <= sum9[DATA_W:1];
            b_r    <= {sum9[0], b_r[DATA_W-1:1]};
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic hs_rsp;
    assign hs_rsp = (state == ST_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (hs_rsp) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule
